// File: rtl/cpu_control_alu.sv
// cpu_control_alu
//   ALU and main control FSM of the multicycle RV32I CPU. The FSM decodes
//   opcode/funct3/funct7 from the instruction register and drives every
//   datapath enable and mux select; the ALU is purely combinational.
//
// Ports
//   clk, reset (async, active-low)
//   opcode/funct3/funct7 : instruction fields from the IR
//   ALUA, ALUB           : ALU operands, ALUResult / Zero : ALU outputs
//   PCEnable, InstructionRegisterEnable, OLDPCEnable, REGAEnable,
//   REGBEnable, MemWrite, RegWrite, InstructionOrData : 1-bit controls
//   ImmediateSrc (0 I,1 S,2 B,3 U,4 J), ALUSrcA, ALUSrcB, ALUControlSignal,
//   ResultSrc : datapath selects
//   halted : illegal-opcode halt flag
//
// Build option
//   CU_ILLEGAL_HALT_EN : when defined, an unknown opcode parks the FSM in
//   HALT until reset; otherwise it is treated as a NOP and halted is 0.
module cpu_control_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] ALUA,
  input  logic [XLEN-1:0] ALUB,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            PCEnable,
  output logic            InstructionRegisterEnable,
  output logic            OLDPCEnable,
  output logic            REGAEnable,
  output logic            REGBEnable,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic            InstructionOrData,
  output logic [2:0]      ImmediateSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [3:0]      ALUControlSignal,
  output logic [1:0]      ResultSrc,
  output logic            halted
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  typedef enum logic [4:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    BRANCH, JAL_JUMP, JALR_ADDR, JALR_JUMP, LINK, LUI, AUIPC
`ifdef CU_ILLEGAL_HALT_EN
    , HALT
`endif
  } state_t;

  state_t state, next_state;

  logic       pc_en, ir_en, oldpc_en, rega_en, regb_en, mem_write, reg_write, iord;
  logic       branch, take;
  logic [2:0] imm_src;
  logic [1:0] src_a, src_b, result_src;
  logic [3:0] alu_ctl;
`ifdef CU_ILLEGAL_HALT_EN
  logic       halt_flag;
`endif

  // Only funct7[5] distinguishes RV32I operations.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // R/I arithmetic decode; immediates never select SUB.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic logic [3:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001: return OP_SUB;
      3'b100, 3'b101: return OP_SLT;
      3'b110, 3'b111: return OP_SLTU;
      default:        return OP_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    oldpc_en   = 1'b0;
    rega_en    = 1'b0;
    regb_en    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    branch     = 1'b0;
    imm_src    = 3'd0;
    src_a      = 2'b00;
    src_b      = 2'b00;
    result_src = 2'b00;
    alu_ctl    = OP_ADD;
`ifdef CU_ILLEGAL_HALT_EN
    halt_flag  = 1'b0;
`endif
    case (state)
      FETCH: begin
        ir_en = 1'b1; oldpc_en = 1'b1; pc_en = 1'b1;
        src_b = 2'b10; result_src = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOUT while operands load.
        rega_en = 1'b1; regb_en = 1'b1;
        src_a = 2'b01; src_b = 2'b01; imm_src = 3'd2;
        case (opcode)
          7'b0110011:             next_state = EXEC_R;
          7'b0010011:             next_state = EXEC_I;
          7'b0000011, 7'b0100011: next_state = MEMADR;
          7'b1100011:             next_state = BRANCH;
          7'b1101111:             next_state = JAL_JUMP;
          7'b1100111:             next_state = JALR_ADDR;
          7'b0110111:             next_state = LUI;
          7'b0010111:             next_state = AUIPC;
`ifdef CU_ILLEGAL_HALT_EN
          default:                next_state = HALT;
`else
          default:                next_state = FETCH;
`endif
        endcase
      end
      EXEC_R: begin
        src_a = 2'b10; src_b = 2'b00;
        alu_ctl = alu_decode(funct3, funct7[5], 1'b1);
        next_state = ALUWB;
      end
      EXEC_I: begin
        src_a = 2'b10; src_b = 2'b01; imm_src = 3'd0;
        alu_ctl = alu_decode(funct3, funct7[5], 1'b0);
        next_state = ALUWB;
      end
      ALUWB:  begin reg_write = 1'b1; next_state = FETCH; end
      MEMADR: begin
        src_a = 2'b10; src_b = 2'b01;
        imm_src = opcode[5] ? 3'd1 : 3'd0;
        next_state = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD:  begin iord = 1'b1; next_state = MEMWB; end
      MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; next_state = FETCH; end
      MEMWRITE: begin iord = 1'b1; mem_write = 1'b1; next_state = FETCH; end
      BRANCH: begin
        src_a = 2'b10; src_b = 2'b00;
        alu_ctl = branch_op(funct3);
        branch = 1'b1;
        next_state = FETCH;
      end
      JAL_JUMP: begin
        src_a = 2'b01; src_b = 2'b01; imm_src = 3'd4;
        result_src = 2'b10; pc_en = 1'b1;
        next_state = LINK;
      end
      JALR_ADDR: begin
        src_a = 2'b10; src_b = 2'b01; imm_src = 3'd0;
        next_state = JALR_JUMP;
      end
      JALR_JUMP: begin pc_en = 1'b1; next_state = LINK; end
      LINK: begin
        // rd = OLDPC + 4
        src_a = 2'b01; src_b = 2'b10; result_src = 2'b10; reg_write = 1'b1;
        next_state = FETCH;
      end
      LUI: begin
        imm_src = 3'd3; result_src = 2'b11; reg_write = 1'b1;
        next_state = FETCH;
      end
      AUIPC: begin
        src_a = 2'b01; src_b = 2'b01; imm_src = 3'd3;
        result_src = 2'b10; reg_write = 1'b1;
        next_state = FETCH;
      end
`ifdef CU_ILLEGAL_HALT_EN
      HALT: begin halt_flag = 1'b1; next_state = HALT; end
`endif
      default: next_state = FETCH;
    endcase
  end

  // Branch decision is kept outside the FSM process so the ALU feedback
  // through Zero does not form a combinational loop inside one block.
  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: take = Zero;
      3'b001, 3'b100, 3'b110: take = !Zero;
      default:                take = 1'b0;
    endcase
  end

  // All controls are forced low while reset is held.
  assign PCEnable                  = reset & (pc_en | (branch & take));
  assign InstructionRegisterEnable = reset & ir_en;
  assign OLDPCEnable               = reset & oldpc_en;
  assign REGAEnable                = reset & rega_en;
  assign REGBEnable                = reset & regb_en;
  assign MemWrite                  = reset & mem_write;
  assign RegWrite                  = reset & reg_write;
  assign InstructionOrData         = reset & iord;
  assign ImmediateSrc              = reset ? imm_src    : 3'd0;
  assign ALUSrcA                   = reset ? src_a      : 2'b00;
  assign ALUSrcB                   = reset ? src_b      : 2'b00;
  assign ALUControlSignal          = reset ? alu_ctl    : 4'd0;
  assign ResultSrc                 = reset ? result_src : 2'b00;
`ifdef CU_ILLEGAL_HALT_EN
  assign halted                    = reset & halt_flag;
`else
  assign halted                    = 1'b0;
`endif

  logic signed [XLEN-1:0] a_s, b_s;
  logic        [4:0]      shamt;
  assign a_s   = ALUA;
  assign b_s   = ALUB;
  assign shamt = ALUB[4:0];

  always_comb begin
    ALUResult = '0;
    case (ALUControlSignal)
      OP_ADD:  ALUResult = ALUA + ALUB;
      OP_SUB:  ALUResult = ALUA - ALUB;
      OP_AND:  ALUResult = ALUA & ALUB;
      OP_OR:   ALUResult = ALUA | ALUB;
      OP_XOR:  ALUResult = ALUA ^ ALUB;
      OP_SLL:  ALUResult = ALUA << shamt;
      OP_SRL:  ALUResult = ALUA >> shamt;
      OP_SRA:  ALUResult = a_s >>> shamt;
      OP_SLT:  ALUResult = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: ALUResult = {{(XLEN-1){1'b0}}, (ALUA < ALUB)};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_cpu_control_alu.sv
module tb_cpu_control_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] ALUA, ALUB;
  logic [31:0] ALUResult;
  logic        Zero, PCEnable, InstructionRegisterEnable, OLDPCEnable, REGAEnable;
  logic        REGBEnable, MemWrite, RegWrite, InstructionOrData, halted;
  logic [2:0]  ImmediateSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUControlSignal;

  int n_cmp = 0;
  int n_err = 0;

  cpu_control_alu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .ALUA(ALUA), .ALUB(ALUB), .ALUResult(ALUResult), .Zero(Zero),
    .PCEnable(PCEnable), .InstructionRegisterEnable(InstructionRegisterEnable),
    .OLDPCEnable(OLDPCEnable), .REGAEnable(REGAEnable), .REGBEnable(REGBEnable),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .InstructionOrData(InstructionOrData),
    .ImmediateSrc(ImmediateSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControlSignal(ALUControlSignal), .ResultSrc(ResultSrc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 7'h00, 32'd3,        32'd4,        4'd0, 32'd7};
    vecs[1]  = '{7'b0110011, 3'b000, 7'h20, 32'd5,        32'd5,        4'd1, 32'd0};
    vecs[2]  = '{7'b0110011, 3'b001, 7'h00, 32'd1,        32'h2F,       4'd5, 32'h0000_8000};
    vecs[3]  = '{7'b0110011, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        4'd8, 32'd1};
    vecs[4]  = '{7'b0110011, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        4'd9, 32'd0};
    vecs[5]  = '{7'b0110011, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0};
    vecs[6]  = '{7'b0110011, 3'b101, 7'h00, 32'h80000000, 32'd4,        4'd6, 32'h08000000};
    vecs[7]  = '{7'b0110011, 3'b101, 7'h20, 32'h80000000, 32'd4,        4'd7, 32'hF8000000};
    vecs[8]  = '{7'b0110011, 3'b110, 7'h00, 32'h0000F000, 32'h0000000F, 4'd3, 32'h0000F00F};
    vecs[9]  = '{7'b0110011, 3'b111, 7'h00, 32'h12345678, 32'h0F0F0F0F, 4'd2, 32'h02040608};
    vecs[10] = '{7'b0010011, 3'b000, 7'h20, 32'd10,       32'hFFFFFFFF, 4'd0, 32'd9};
    vecs[11] = '{7'b0010011, 3'b101, 7'h20, 32'hFFFFFF00, 32'd8,        4'd7, 32'hFFFFFFFF};
    vecs[12] = '{7'b0010011, 3'b010, 7'h00, 32'd2,        32'd3,        4'd8, 32'd1};

    reset = 1'b0;
    set_instr(7'b0110011, 3'b000, 7'h00);
    ALUA = 32'd1; ALUB = 32'd2;

    // Reset held: every control low.
    #12;
    chk("rst_pcen",   {31'd0, PCEnable}, 32'd0);
    chk("rst_iren",   {31'd0, InstructionRegisterEnable}, 32'd0);
    chk("rst_oldpc",  {31'd0, OLDPCEnable}, 32'd0);
    chk("rst_regwr",  {31'd0, RegWrite}, 32'd0);
    chk("rst_srcb",   {30'd0, ALUSrcB}, 32'd0);
    chk("rst_ressrc", {30'd0, ResultSrc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Release: FETCH.
    reset = 1'b1;
    #1;
    chk("fetch_pcen",   {31'd0, PCEnable}, 32'd1);
    chk("fetch_iren",   {31'd0, InstructionRegisterEnable}, 32'd1);
    chk("fetch_oldpc",  {31'd0, OLDPCEnable}, 32'd1);
    chk("fetch_srcb",   {30'd0, ALUSrcB}, 32'd2);
    chk("fetch_ressrc", {30'd0, ResultSrc}, 32'd2);
    chk("fetch_ctl",    {28'd0, ALUControlSignal}, 32'd0);

    // R/I-type ALU vectors: FETCH, DECODE, EXEC, ALUWB, FETCH.
    for (int i = 0; i < 13; i++) begin
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7);
      ALUA = vecs[i].a; ALUB = vecs[i].b;
      step();
      if (i == 0) begin
        chk("dec_rega", {31'd0, REGAEnable}, 32'd1);
        chk("dec_regb", {31'd0, REGBEnable}, 32'd1);
        chk("dec_srca", {30'd0, ALUSrcA}, 32'd1);
        chk("dec_srcb", {30'd0, ALUSrcB}, 32'd1);
        chk("dec_imm",  {29'd0, ImmediateSrc}, 32'd2);
      end
      step();
      chk($sformatf("v%0d_ctl", i),  {28'd0, ALUControlSignal}, {28'd0, vecs[i].ctl});
      chk($sformatf("v%0d_res", i),  ALUResult, vecs[i].res);
      chk($sformatf("v%0d_zero", i), {31'd0, Zero}, {31'd0, (vecs[i].res == 32'd0)});
      chk($sformatf("v%0d_srca", i), {30'd0, ALUSrcA}, 32'd2);
      chk($sformatf("v%0d_srcb", i), {30'd0, ALUSrcB}, (vecs[i].op == 7'b0010011) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("v%0d_wb", i),     {31'd0, RegWrite}, 32'd1);
      chk($sformatf("v%0d_wbsrc", i),  {30'd0, ResultSrc}, 32'd0);
      step();
      chk($sformatf("v%0d_fetch", i),  {31'd0, InstructionRegisterEnable}, 32'd1);
    end

    // BNE: equal operands do not branch, different ones do.
    set_instr(7'b1100011, 3'b001, 7'h00);
    ALUA = 32'd7; ALUB = 32'd7;
    step(); step();
    chk("bne_ctl",   {28'd0, ALUControlSignal}, 32'd1);
    chk("bne_eq",    {31'd0, PCEnable}, 32'd0);
    ALUB = 32'd8; #1;
    chk("bne_ne",    {31'd0, PCEnable}, 32'd1);
    step();
    chk("bne_fetch", {31'd0, InstructionRegisterEnable}, 32'd1);

    // BGE: -1 >= 1 false, 5 >= 1 true.
    set_instr(7'b1100011, 3'b101, 7'h00);
    ALUA = 32'hFFFFFFFF; ALUB = 32'd1;
    step(); step();
    chk("bge_ctl",   {28'd0, ALUControlSignal}, 32'd8);
    chk("bge_lt",    {31'd0, PCEnable}, 32'd0);
    ALUA = 32'd5; #1;
    chk("bge_ge",    {31'd0, PCEnable}, 32'd1);
    step();

    // LW: 5 cycles.
    set_instr(7'b0000011, 3'b010, 7'h00);
    step(); step();
    chk("lw_adr_imm",  {29'd0, ImmediateSrc}, 32'd0);
    chk("lw_adr_srca", {30'd0, ALUSrcA}, 32'd2);
    step();
    chk("lw_rd_iord",  {31'd0, InstructionOrData}, 32'd1);
    chk("lw_rd_regwr", {31'd0, RegWrite}, 32'd0);
    step();
    chk("lw_wb_src",   {30'd0, ResultSrc}, 32'd1);
    chk("lw_wb_regwr", {31'd0, RegWrite}, 32'd1);
    step();
    chk("lw_fetch",    {31'd0, InstructionRegisterEnable}, 32'd1);

    // SW: 4 cycles, MemWrite exactly one cycle.
    set_instr(7'b0100011, 3'b010, 7'h00);
    step();
    chk("sw_dec_mw",  {31'd0, MemWrite}, 32'd0);
    step();
    chk("sw_adr_imm", {29'd0, ImmediateSrc}, 32'd1);
    chk("sw_adr_mw",  {31'd0, MemWrite}, 32'd0);
    step();
    chk("sw_mw",      {31'd0, MemWrite}, 32'd1);
    chk("sw_iord",    {31'd0, InstructionOrData}, 32'd1);
    step();
    chk("sw_fetch_mw", {31'd0, MemWrite}, 32'd0);
    chk("sw_fetch",    {31'd0, InstructionRegisterEnable}, 32'd1);

    // JALR: 5 cycles.
    set_instr(7'b1100111, 3'b000, 7'h00);
    step(); step();
    chk("jalr_adr_srca", {30'd0, ALUSrcA}, 32'd2);
    chk("jalr_adr_pcen", {31'd0, PCEnable}, 32'd0);
    step();
    chk("jalr_j_pcen",   {31'd0, PCEnable}, 32'd1);
    chk("jalr_j_src",    {30'd0, ResultSrc}, 32'd0);
    step();
    chk("jalr_l_regwr",  {31'd0, RegWrite}, 32'd1);
    chk("jalr_l_srca",   {30'd0, ALUSrcA}, 32'd1);
    chk("jalr_l_srcb",   {30'd0, ALUSrcB}, 32'd2);
    step();
    chk("jalr_fetch",    {31'd0, InstructionRegisterEnable}, 32'd1);

    // JAL: 4 cycles.
    set_instr(7'b1101111, 3'b000, 7'h00);
    step(); step();
    chk("jal_imm",  {29'd0, ImmediateSrc}, 32'd4);
    chk("jal_pcen", {31'd0, PCEnable}, 32'd1);
    step();
    chk("jal_link", {31'd0, RegWrite}, 32'd1);
    step();

    // LUI: 3 cycles.
    set_instr(7'b0110111, 3'b000, 7'h00);
    step(); step();
    chk("lui_imm",   {29'd0, ImmediateSrc}, 32'd3);
    chk("lui_src",   {30'd0, ResultSrc}, 32'd3);
    chk("lui_regwr", {31'd0, RegWrite}, 32'd1);
    step();
    chk("lui_fetch", {31'd0, InstructionRegisterEnable}, 32'd1);

    // Reset in EXEC_R: nothing written afterwards.
    set_instr(7'b0110011, 3'b000, 7'h00);
    step(); step();
    reset = 1'b0; #1;
    chk("midrst_srca",  {30'd0, ALUSrcA}, 32'd0);
    chk("midrst_regwr", {31'd0, RegWrite}, 32'd0);
    reset = 1'b1; #1;
    chk("midrst_fetch", {31'd0, InstructionRegisterEnable}, 32'd1);
    chk("midrst_f_wr",  {31'd0, RegWrite}, 32'd0);
    step();
    chk("midrst_dec_wr",   {31'd0, RegWrite}, 32'd0);
    chk("midrst_dec_rega", {31'd0, REGAEnable}, 32'd1);
    step(); step(); step();

    // Unknown opcode.
    set_instr(7'b0000000, 3'b000, 7'h00);
    step(); step();
`ifdef CU_ILLEGAL_HALT_EN
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_pcen",   {31'd0, PCEnable}, 32'd0);
    chk("ill_iren",   {31'd0, InstructionRegisterEnable}, 32'd0);
    step();
    chk("ill_stay",   {31'd0, halted}, 32'd1);
    reset = 1'b0; #1;
    chk("ill_rst",    {31'd0, halted}, 32'd0);
    reset = 1'b1; #1;
    chk("ill_fetch",  {31'd0, InstructionRegisterEnable}, 32'd1);
`else
    chk("ill_fetch",  {31'd0, InstructionRegisterEnable}, 32'd1);
    chk("ill_halted", {31'd0, halted}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
